apb_reg_slave: RTL

//   APB completer (responder) for the subsystem's driver/monitor interface.

---
 rtl/apb_reg_slave.sv | 132 +++++++++++++
 1 files changed

// File: rtl/apb_reg_slave.sv
// APB completer serving a bank of 32-bit registers with configurable wait states.
// Define APB_SLV_PSLVERR_EN to report invalid accesses on pslverr_o; otherwise pslverr_o is 0.
module apb_reg_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
   input  logic        pclk_i,
   input  logic        presetn_i,
   input  logic [31:0] paddr_i,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic        pwrite_i,
   input  logic [31:0] pwdata_i,
   output logic [31:0] prdata_o,
   output logic        pready_o,
   output logic        pslverr_o
);

   localparam int unsigned CntW     = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [31:0] WinBytes = 32'(4 * NUM_REGS);

   typedef enum logic {StIdle, StAccess} state_e;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic              write_q;
   logic              pready_q;
   logic              pslverr_q;
   logic [31:0]       prdata_q;
   logic [31:0]       regs_q [1:NUM_REGS-1];

   logic [31:0]       cur_addr;
   logic              cur_write;
   logic [31:0]       off;
   logic              cur_valid;
   logic [7:0]        cur_idx;
   logic              cur_err;
   logic [31:0]       rd_word;
   logic [31:0]       rd_val;
   logic              err_val;
   logic              commit;

   // Decode the live bus in IDLE (setup edge) and the latched transfer afterwards.
   always_comb begin
      cur_addr  = (state_q == StIdle) ? paddr_i : addr_q;
      cur_write = (state_q == StIdle) ? pwrite_i : write_q;
      off       = cur_addr - BASE_ADDR;
      cur_valid = (cur_addr >= BASE_ADDR) && (off < WinBytes);
      cur_idx   = off[9:2];
      cur_err   = !cur_valid || (cur_write && (cur_idx == 8'd0));
      rd_word   = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (cur_idx == 8'(i)) rd_word = regs_q[i];
      end
      rd_val    = (!cur_write && !cur_err) ? rd_word : '0;
`ifdef APB_SLV_PSLVERR_EN
      err_val   = cur_err;
`else
      err_val   = 1'b0;
`endif
      commit    = (state_q == StAccess) && pready_q && psel_i && penable_i && write_q && !cur_err;
   end

   always_ff @(posedge pclk_i) begin
      if (!presetn_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (psel_i && !penable_i) begin
                  addr_q  <= paddr_i;
                  write_q <= pwrite_i;
                  wdata_q <= pwdata_i;
                  cnt_q   <= CntW'(WAIT_CYCLES);
                  state_q <= StAccess;
                  if (WAIT_CYCLES == 0) begin
                     pready_q  <= 1'b1;
                     prdata_q  <= rd_val;
                     pslverr_q <= err_val;
                  end
               end
            end
            StAccess: begin
               if (!pready_q) begin
                  if (!psel_i) begin
                     state_q <= StIdle;
                  end else begin
                     cnt_q <= cnt_q - CntW'(1);
                     if (cnt_q == CntW'(1)) begin
                        pready_q  <= 1'b1;
                        prdata_q  <= rd_val;
                        pslverr_q <= err_val;
                     end
                  end
               end else begin
                  pready_q  <= 1'b0;
                  prdata_q  <= '0;
                  pslverr_q <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge pclk_i) begin
      if (!presetn_i) begin
         for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (commit) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (cur_idx == 8'(i)) regs_q[i] <= wdata_q;
         end
      end
   end

   assign prdata_o  = prdata_q;
   assign pready_o  = pready_q;
   assign pslverr_o = pslverr_q;

endmodule
